// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - arbitrates drawing engines onto the single VGA pixel-write port (optional ARB_ROUND_ROBIN_EN)
module vga_write_arbiter #(
    parameter int N        = 4,
    parameter int COLOUR_W = 3,
    parameter int MAX_HOLD = 20000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          valid,
    input  logic [8*N-1:0]        x_in,
    input  logic [7*N-1:0]        y_in,
    input  logic [COLOUR_W*N-1:0] colour_in,
    output logic [N-1:0]          grant,
    output logic                  busy,
    output logic                  timeout,
    output logic [7:0]            vga_x,
    output logic [6:0]            vga_y,
    output logic [COLOUR_W-1:0]   vga_colour,
    output logic                  vga_plot,
    output logic [15:0]           pixel_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [15:0] HOLD_LAST = (MAX_HOLD > 0) ? 16'(MAX_HOLD - 1) : 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OWN     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_n;
    logic [N-1:0]          r_grant;
    logic [IW-1:0]         r_owner;
    logic [15:0]           r_hold;
    logic                  r_timeout;
    logic [7:0]            r_vga_x;
    logic [6:0]            r_vga_y;
    logic [COLOUR_W-1:0]   r_vga_colour;
    logic                  r_vga_plot;
    logic [15:0]           r_count;

    logic [IW-1:0]         w_win;
    logic                  w_load;
    logic                  w_timeout_n;
    logic                  w_hold_hit;
    logic                  w_oreq;
    logic                  w_ovalid;
    logic [7:0]            w_ox;
    logic [6:0]            w_oy;
    logic [COLOUR_W-1:0]   w_oc;
    logic                  w_in_range;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         w_idx;
    logic                  w_found;

    // Round robin: first requester after the pointer, searching cyclically
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(r_ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Pointer follows the most recent winner
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr <= IW'(N - 1);
        end else if (w_load) begin
            r_ptr <= w_win;
        end
    end
`else
    // Fixed priority: lowest requesting index wins
    always_comb begin
        w_win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win = IW'(i);
            end
        end
    end
`endif

    // Select the owner's request, valid and pixel slice
    always_comb begin
        w_oreq   = 1'b0;
        w_ovalid = 1'b0;
        w_ox     = '0;
        w_oy     = '0;
        w_oc     = '0;
        for (int i = 0; i < N; i++) begin
            if (r_owner == IW'(i)) begin
                w_oreq   = req[i];
                w_ovalid = valid[i];
                w_ox     = x_in[8*i +: 8];
                w_oy     = y_in[7*i +: 7];
                w_oc     = colour_in[COLOUR_W*i +: COLOUR_W];
            end
        end
    end

    assign w_in_range = (w_ox < 8'd160) && (w_oy < 7'd120);
    assign w_hold_hit = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);

    // Next-state logic: grant from IDLE, release on req drop or hold limit
    always_comb begin
        w_state_n   = r_state;
        w_load      = 1'b0;
        w_timeout_n = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_n = S_OWN;
                    w_load    = 1'b1;
                end
            end
            S_OWN: begin
                if (!w_oreq || w_hold_hit) begin
                    w_state_n   = S_RELEASE;
                    w_timeout_n = w_oreq && w_hold_hit;
                end
            end
            S_RELEASE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // State, grant, owner and hold counter registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_timeout <= w_timeout_n;
            if (w_load) begin
                r_grant <= {{(N-1){1'b0}}, 1'b1} << w_win;
                r_owner <= w_win;
                r_hold  <= '0;
            end else if (r_state == S_OWN) begin
                r_hold <= r_hold + 16'd1;
                if (w_state_n == S_RELEASE) begin
                    r_grant <= '0;
                end
            end
        end
    end

    // Registered pixel output stage and burst pixel counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
            r_count      <= '0;
        end else begin
            r_vga_plot <= 1'b0;
            if (w_load) begin
                r_count <= '0;
            end else if (r_state == S_OWN && w_ovalid && w_in_range) begin
                r_vga_x      <= w_ox;
                r_vga_y      <= w_oy;
                r_vga_colour <= w_oc;
                r_vga_plot   <= 1'b1;
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end
        end
    end

    assign grant       = r_grant;
    assign busy        = (r_state != S_IDLE);
    assign timeout     = r_timeout;
    assign vga_x       = r_vga_x;
    assign vga_y       = r_vga_y;
    assign vga_colour  = r_vga_colour;
    assign vga_plot    = r_vga_plot;
    assign pixel_count = r_count;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb/tb_vga_write_arbiter.sv - scoreboard bench for vga_write_arbiter
module tb_vga_write_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [3:0]  valid;
    logic [31:0] x_in;
    logic [27:0] y_in;
    logic [11:0] colour_in;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [15:0] pixel_count;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    vga_write_arbiter #(.N(4), .COLOUR_W(3), .MAX_HOLD(8)) dut (
        .clk(clk),
        .resetn(resetn),
        .req(req),
        .valid(valid),
        .x_in(x_in),
        .y_in(y_in),
        .colour_in(colour_in),
        .grant(grant),
        .busy(busy),
        .timeout(timeout),
        .vga_x(vga_x),
        .vga_y(vga_y),
        .vga_colour(vga_colour),
        .vga_plot(vga_plot),
        .pixel_count(pixel_count)
    );

    always #5 clk = ~clk;

    task automatic drive_pix(input int i, input logic [7:0] x, input logic [6:0] y,
                             input logic [2:0] c, input bit expect_write);
        pix_t p;
        valid[i] = 1'b1;
        x_in[8*i +: 8] = x;
        y_in[7*i +: 7] = y;
        colour_in[3*i +: 3] = c;
        if (expect_write) begin
            p.x = x;
            p.y = y;
            p.c = c;
            q.push_back(p);
        end
    endtask

    // One clock; pixel scoreboard pops whatever was expected at this edge
    task automatic tick();
        pix_t p;
        logic exp_plot;
        @(posedge clk);
        #1;
        exp_plot = (q.size() > 0);
        n_checks++;
        if (vga_plot !== exp_plot) begin
            n_fail++;
            $display("FAIL plot: got %b want %b at %0t", vga_plot, exp_plot, $time);
        end
        if (exp_plot) begin
            p = q.pop_front();
            n_checks++;
            if ({vga_x, vga_y, vga_colour} !== {p.x, p.y, p.c}) begin
                n_fail++;
                $display("FAIL pixel: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                         vga_x, vga_y, vga_colour, p.x, p.y, p.c);
            end
        end
        valid = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({grant, busy, timeout, vga_plot, vga_x, vga_y, vga_colour, pixel_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got g=%b b=%b t=%b p=%b x=%0d y=%0d c=%0d n=%0d want all 0",
                     grant, busy, timeout, vga_plot, vga_x, vga_y, vga_colour, pixel_count);
        end
        resetn = 1'b1;
    endtask

    task automatic test_pixels();
        req = 4'b0001;
        tick();
        n_checks++;
        if (grant !== 4'b0001 || busy !== 1'b1 || pixel_count !== 16'd0) begin
            n_fail++;
            $display("FAIL grant0: got g=%b b=%b n=%0d want 0001 1 0", grant, busy, pixel_count);
        end
        drive_pix(0, 8'd10, 7'd5, 3'd1, 1'b1);
        tick();
        drive_pix(0, 8'd11, 7'd5, 3'd2, 1'b1);
        tick();
        drive_pix(0, 8'd159, 7'd119, 3'd7, 1'b1);
        tick();
        n_checks++;
        if (pixel_count !== 16'd3) begin
            n_fail++;
            $display("FAIL count3: got %0d want 3", pixel_count);
        end
        drive_pix(0, 8'd160, 7'd0, 3'd3, 1'b0);
        tick();
        drive_pix(0, 8'd0, 7'd120, 3'd4, 1'b0);
        tick();
        n_checks++;
        if (pixel_count !== 16'd3) begin
            n_fail++;
            $display("FAIL count_oor: got %0d want 3", pixel_count);
        end
        req = 4'b0000;
        tick();
        n_checks++;
        if (grant !== 4'b0000 || busy !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL release0: got g=%b b=%b t=%b want 0000 1 0", grant, busy, timeout);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || pixel_count !== 16'd3) begin
            n_fail++;
            $display("FAIL idle0: got b=%b n=%0d want 0 3", busy, pixel_count);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [3];
`ifdef ARB_ROUND_ROBIN_EN
        exp_g[0] = 4'b0010;
        exp_g[1] = 4'b1000;
        exp_g[2] = 4'b0010;
`else
        exp_g[0] = 4'b0010;
        exp_g[1] = 4'b0010;
        exp_g[2] = 4'b0010;
`endif
        req = 4'b1010;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (grant !== exp_g[k]) begin
                n_fail++;
                $display("FAIL arb_grant%0d: got %b want %b", k, grant, exp_g[k]);
            end
            tick();
            tick();
            req = req & ~exp_g[k];
            tick();
            n_checks++;
            if (grant !== 4'b0000 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL arb_release%0d: got g=%b b=%b want 0000 1", k, grant, busy);
            end
            req = (k < 2) ? 4'b1010 : 4'b0000;
            tick();
            n_checks++;
            if (busy !== 1'b0 || grant !== 4'b0000) begin
                n_fail++;
                $display("FAIL arb_gap%0d: got g=%b b=%b want 0000 0", k, grant, busy);
            end
            if (k < 2) begin
                tick();
            end
        end
    endtask

    task automatic test_drop_pixel();
        req = 4'b0100;
        tick();
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL drop_grant: got %b want 0100", grant);
        end
        drive_pix(2, 8'd7, 7'd8, 3'd6, 1'b1);
        req = 4'b0000;
        tick();
        n_checks++;
        if (grant !== 4'b0000 || pixel_count !== 16'd1) begin
            n_fail++;
            $display("FAIL drop_pixel: got g=%b n=%0d want 0000 1", grant, pixel_count);
        end
        tick();
    endtask

    task automatic test_timeout();
        req = 4'b0100;
        tick();
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL to_grant: got %b want 0100", grant);
        end
        for (int j = 0; j < 7; j++) begin
            tick();
            n_checks++;
            if (grant !== 4'b0100 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL to_hold%0d: got g=%b t=%b want 0100 0", j, grant, timeout);
            end
        end
        tick();
        n_checks++;
        if (grant !== 4'b0000 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_pulse: got g=%b t=%b want 0000 1", grant, timeout);
        end
        tick();
        n_checks++;
        if (timeout !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_gap: got t=%b b=%b want 0 0", timeout, busy);
        end
        tick();
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL to_regrant: got %b want 0100", grant);
        end
        req = 4'b0000;
        tick();
        n_checks++;
        if (timeout !== 1'b0 || grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL to_normal: got t=%b g=%b want 0 0000", timeout, grant);
        end
        tick();
    endtask

    task automatic test_non_owner();
        req = 4'b0010;
        tick();
        n_checks++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL no_grant: got %b want 0010", grant);
        end
        drive_pix(3, 8'd1, 7'd1, 3'd5, 1'b0);
        tick();
        drive_pix(3, 8'd9, 7'd9, 3'd1, 1'b0);
        drive_pix(1, 8'd40, 7'd50, 3'd3, 1'b1);
        tick();
        n_checks++;
        if (pixel_count !== 16'd1) begin
            n_fail++;
            $display("FAIL no_count: got %0d want 1", pixel_count);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        req = 4'b0010;
        tick();
        drive_pix(1, 8'd5, 7'd5, 3'd2, 1'b1);
        tick();
        n_checks++;
        if (pixel_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mr_count: got %0d want 1", pixel_count);
        end
        drive_pix(1, 8'd6, 7'd6, 3'd4, 1'b0);
        resetn = 1'b0;
        tick();
        n_checks++;
        if (grant !== 4'b0000 || vga_plot !== 1'b0 || pixel_count !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mr_abort: got g=%b p=%b n=%0d b=%b want 0000 0 0 0",
                     grant, vga_plot, pixel_count, busy);
        end
        resetn = 1'b1;
        req = 4'b1010;
        tick();
        n_checks++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL mr_first: got %b want 0010", grant);
        end
        req = 4'b0000;
        tick();
        tick();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_empty: got %0d pending want 0", q.size());
        end
    endtask

    initial begin
        resetn    = 1'b0;
        req       = '0;
        valid     = '0;
        x_in      = '0;
        y_in      = '0;
        colour_in = '0;
        test_reset();
        test_pixels();
        test_round_robin();
        test_drop_pixel();
        test_timeout();
        test_non_owner();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
